// File: rtl/green_feature_extractor.sv
// green_feature_extractor: streaming HSV green-threshold front end of the
// rock/paper/scissors classifier. Accepts one raster-order pixel per cycle,
// masks it against an inclusive [lower, upper] box on H, S and V, and
// accumulates the frame features the classifier consumes.
// Latency: feat_valid rises one cycle after the last pixel handshake.
// Backpressure: pix_ready is low outside STREAM; features are held until feat_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a new frame (only honoured in IDLE)
//   lower, upper        threshold box, [23:16]=H [15:8]=S [7:0]=V
//   pix_valid/ready/data  pixel stream, same HSV packing
//   feat_valid/ready    feature handshake (held until taken)
//   sum, sum_left       in-range pixel counts (whole frame / column < LENGTH/2)
//   strip               mask of column STRIP_COL, bit r = row r
//   transitions         adjacent-row changes along the strip
//   busy                high whenever a frame is in progress or unread
module green_feature_extractor #(
  parameter int HEIGHT    = 64,
  parameter int LENGTH    = 64,
  parameter int STRIP_COL = LENGTH / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       lower,
  input  logic [23:0]       upper,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [23:0]       pix_data,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic [31:0]       sum,
  output logic [31:0]       sum_left,
  output logic [HEIGHT-1:0] strip,
  output logic [31:0]       transitions,
  output logic              busy
);

  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(LENGTH);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LENGTH - 1);
  localparam logic [COL_W-1:0] COL_HALF = COL_W'(LENGTH / 2);
  localparam logic [COL_W-1:0] COL_STRIP = COL_W'(STRIP_COL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [23:0]      lower_q, upper_q;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             prev_bit;
  logic             accept;
  logic             last_pix;
  logic             mask;

  // Unsigned inclusive compare per channel; a low>high channel can never pass.
  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign mask = in_range(pix_data[23:16], lower_q[23:16], upper_q[23:16]) &&
                in_range(pix_data[15:8],  lower_q[15:8],  upper_q[15:8])  &&
                in_range(pix_data[7:0],   lower_q[7:0],   upper_q[7:0]);

  // Handshake outputs decode straight from the state register, so they are
  // glitch-free and pix_ready is already high on the first STREAM cycle.
  assign pix_ready  = (state_q == STREAM);
  assign feat_valid = (state_q == HOLD);
  assign busy       = (state_q != IDLE);

  assign accept   = pix_valid && pix_ready;
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && last_pix) state_d = HOLD;
      HOLD:    if (feat_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lower_q     <= '0;
      upper_q     <= '0;
      sum         <= '0;
      sum_left    <= '0;
      transitions <= '0;
      strip       <= '0;
      row         <= '0;
      col         <= '0;
      prev_bit    <= 1'b0;
    end else if (state_q == IDLE && start) begin
      // Thresholds are captured once per frame so the box cannot shift mid-frame.
      lower_q     <= lower;
      upper_q     <= upper;
      sum         <= '0;
      sum_left    <= '0;
      transitions <= '0;
      strip       <= '0;
      row         <= '0;
      col         <= '0;
    end else if (accept) begin
      sum <= sum + {31'd0, mask};
      if (col < COL_HALF) begin
        sum_left <= sum_left + {31'd0, mask};
      end
      if (col == COL_STRIP) begin
        strip[row] <= mask;
        prev_bit   <= mask;
        // Row 0 has no predecessor, so whatever prev_bit holds is ignored there.
        if (row != '0 && mask != prev_bit) begin
          transitions <= transitions + 32'd1;
        end
      end
      if (col == COL_LAST) begin
        col <= '0;
        row <= last_pix ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_green_feature_extractor.sv
module tb_green_feature_extractor;

  localparam int H = 4;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] lower = 24'h241919;
  logic [23:0] upper = 24'h56FFFF;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [23:0] pix_data = 24'h0;
  logic        feat_valid;
  logic        feat_ready = 1'b0;
  logic [31:0] sum, sum_left, transitions;
  logic [H-1:0] strip;
  logic        busy;

  typedef struct packed {
    logic [31:0]  s;
    logic [31:0]  sl;
    logic [H-1:0] st;
    logic [31:0]  tr;
  } feat_t;

  feat_t       exp_q[$];
  logic [23:0] frame[H*L];
  int          errors = 0;
  int          checks = 0;

  green_feature_extractor #(.HEIGHT(H), .LENGTH(L), .STRIP_COL(2)) dut (
    .clk(clk), .rst(rst), .start(start), .lower(lower), .upper(upper),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .sum(sum),
    .sum_left(sum_left), .strip(strip), .transitions(transitions), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input logic [23:0] v);
    for (int i = 0; i < H*L; i++) frame[i] = v;
  endtask

  task automatic push_exp(input logic [31:0] s, input logic [31:0] sl,
                          input logic [H-1:0] st, input logic [31:0] tr);
    feat_t e;
    e.s = s; e.sl = sl; e.st = st; e.tr = tr;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_pix_ready", {31'd0, pix_ready}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
  endtask

  // Offers frame[0..n-1]; with toggle, pix_valid alternates 1/0 each cycle.
  task automatic drive(input int n, input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 200) begin
      @(negedge clk);
      pix_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      pix_data  = frame[idx];
      if (pix_valid && pix_ready) idx++;
      cyc++;
    end
    chk("drive_accepts", idx, n);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic collect(input int hold_cycles, input bit with_start);
    feat_t e;
    int w = 0;
    while (!feat_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("feat_valid_wait", {31'd0, feat_valid}, 32'd1);
    e = exp_q.pop_front();
    chk("sum", sum, e.s);
    chk("sum_left", sum_left, e.sl);
    chk("strip", {28'd0, strip}, {28'd0, e.st});
    chk("transitions", transitions, e.tr);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      chk("hold_feat_valid", {31'd0, feat_valid}, 32'd1);
      chk("hold_pix_ready", {31'd0, pix_ready}, 32'd0);
      chk("hold_sum", sum, e.s);
      chk("hold_strip", {28'd0, strip}, {28'd0, e.st});
      chk("hold_transitions", transitions, e.tr);
    end
    feat_ready = 1'b1;
    start      = with_start;
    @(negedge clk);
    feat_ready = 1'b0;
    start      = 1'b0;
    chk("release_feat_valid", {31'd0, feat_valid}, 32'd0);
    chk("release_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("idle_stays_idle", {31'd0, busy}, 32'd0);
    chk("idle_keeps_sum", sum, e.s);
  endtask

  initial begin
    // Reset, then idle with pix_valid high and no start.
    pix_valid = 1'b1;
    pix_data  = 24'h3C8080;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_pix_ready", {31'd0, pix_ready}, 32'd0);
      chk("idle_feat_valid", {31'd0, feat_valid}, 32'd0);
    end
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_sum_left", sum_left, 32'd0);
    chk("rst_strip", {28'd0, strip}, 32'd0);
    chk("rst_transitions", transitions, 32'd0);
    pix_valid = 1'b0;

    // All-green frame, back-to-back; feat_valid one cycle after the 16th accept.
    fill(24'h3C8080);
    push_exp(32'd16, 32'd8, 4'b1111, 32'd0);
    do_start();
    drive(16, 1'b0);
    chk("latency_feat_valid", {31'd0, feat_valid}, 32'd1);
    chk("latency_pix_ready", {31'd0, pix_ready}, 32'd0);
    collect(0, 1'b0);

    // Strip column 2 rows 0..3 = 1,0,1,1, everything else black.
    fill(24'h000000);
    frame[2]  = 24'h3C8080;
    frame[10] = 24'h3C8080;
    frame[14] = 24'h3C8080;
    push_exp(32'd3, 32'd0, 4'b1101, 32'd2);
    do_start();
    drive(16, 1'b0);
    collect(0, 1'b0);

    // Channel boundaries: 0x24/0x56 H and 0x19 S in range, 0x23/0x57 H and 0x18 S out.
    fill(24'h000000);
    frame[0]  = 24'h241919;
    frame[1]  = 24'h561919;
    frame[2]  = 24'h231919;
    frame[3]  = 24'h571919;
    frame[4]  = 24'h301980;
    frame[5]  = 24'h301880;
    frame[6]  = 24'h24FFFF;
    frame[10] = 24'h56FFFF;
    push_exp(32'd5, 32'd3, 4'b0110, 32'd2);
    do_start();
    drive(16, 1'b0);
    collect(0, 1'b0);

    // Toggled pix_valid, 5-cycle held output; start alongside feat_ready is ignored.
    fill(24'h3C8080);
    push_exp(32'd16, 32'd8, 4'b1111, 32'd0);
    do_start();
    drive(16, 1'b1);
    chk("toggle_latency", {31'd0, feat_valid}, 32'd1);
    collect(5, 1'b1);

    // Reset after 7 accepts, then a clean all-green frame.
    fill(24'h3C8080);
    do_start();
    drive(7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", sum, 32'd0);
    chk("abort_pix_ready", {31'd0, pix_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_exp(32'd16, 32'd8, 4'b1111, 32'd0);
    do_start();
    drive(16, 1'b0);
    collect(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
